multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, one step per state. It drives the enables and mux selects for the program counter, the shared instruction/data memory port, the register file and the ALU operand paths. It also tracks retired instructions and halt/illegal status for the top level.

Parameters:
MEM_LATENCY, 1, memory read latency in cycles (legal 1..4): data is valid MEM_LATENCY cycles after the address is presented.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  permits starting a new instruction; sampled only in FETCH
opcode  in  7  opcode field of the instruction register (IR[6:0])
take_branch  in  1  branch decision from branch comparison logic, valid in EXECUTE
ir_en  out  1  load instruction register from memory read data
pc_en  out  1  update PC this cycle
pc_src  out  2  00 PC+4, 01 PC+imm (taken branch, JAL), 10 (rs1+imm)&~1 (JALR)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
mem_write  out  1  store strobe
reg_write  out  1  register file write enable
wb_sel  out  2  00 ALU, 01 memory read data, 10 PC+4, 11 immediate (LUI)
alu_a_sel  out  1  0 = rs1, 1 = PC (AUIPC)
alu_b_sel  out  1  0 = rs2, 1 = immediate
instret  out  32  retired instruction count
halted  out  1  sticky; set by ECALL/EBREAK
illegal  out  1  sticky; set by an unknown opcode
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = FETCH, instret = 0, halted = 0, illegal = 0.
  - All strobes (ir_en, pc_en, mem_write, reg_write) are 0. All selects are 0.
  - Reset mid-instruction aborts the instruction with no partial write.
- Output decoding: outputs are combinational from the state register and the opcode input. Strobes are asserted only in the states listed below.
- Memory read latency: a latency counter of width 2 is loaded with MEM_LATENCY-1 on entry to FETCH_WAIT and MEM_WAIT, and decrements each cycle. The state exits when the counter reaches 0.
- FETCH:
  - mem_addr_sel = 0.
  - If run = 1, go to FETCH_WAIT; otherwise stay in FETCH.
- FETCH_WAIT:
  - mem_addr_sel = 0.
  - On the counter-zero cycle, assert ir_en = 1 and go to DECODE.
- DECODE: one cycle for the register file read. Next state by opcode:
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP → EXECUTE.
  - 1110011 SYSTEM → HALT.
  - Any other opcode → TRAP.
- EXECUTE:
  - Operand selects: alu_b_sel = 1 for all opcodes except OP and BRANCH. alu_a_sel = 1 only for AUIPC.
  - BRANCH: pc_en = 1, pc_src = 01 if take_branch else 00; instret increments; go to FETCH.
  - LOAD and STORE → MEM.
  - All other opcodes → WRITEBACK.
- MEM:
  - mem_addr_sel = 1.
  - STORE: mem_write = 1 for exactly one cycle, pc_en = 1, pc_src = 00, instret increments; go to FETCH.
  - LOAD: go to MEM_WAIT.
- MEM_WAIT:
  - mem_addr_sel = 1.
  - On the counter-zero cycle, go to WRITEBACK.
- WRITEBACK:
  - reg_write = 1; pc_en = 1; instret increments; go to FETCH.
  - wb_sel: LOAD 01, JAL/JALR 10, LUI 11, otherwise 00.
  - pc_src: JAL 01, JALR 10, otherwise 00.
- HALT: sets halted, asserts no strobes, and stays until reset. The SYSTEM instruction is not counted in instret.
- TRAP: sets illegal, asserts no strobes, and stays until reset.
- Retirement: instret increments exactly on cycles with pc_en = 1. It wraps modulo 2^32.
- Strobe exclusivity: mem_write and reg_write are never asserted in the same cycle. ir_en is never asserted in the same cycle as pc_en.
- run: deasserting run mid-instruction does not stall the instruction; it only holds the FSM in FETCH afterwards.
- Cycles per instruction (MEM_LATENCY = L): branch 3+L; store 4+L; ALU/LUI/AUIPC/JAL/JALR 4+L; load 5+2L.

Test Plan:
- Reset, then run = 1 with an ADDI opcode (0010011), L = 1 → states FETCH, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK. reg_write = 1, wb_sel = 00 and pc_en = 1 only in cycle 5; instret = 1.
- LOAD with L = 3 → ir_en in cycle 4, mem_addr_sel = 1 during MEM plus 3 MEM_WAIT cycles, reg_write with wb_sel = 01 in cycle 11; no mem_write at any point.
- BRANCH, L = 1: take_branch = 1 → pc_src = 01, pc_en in cycle 4, reg_write never asserted. Repeat with take_branch = 0 → pc_src = 00.
- JALR then STORE back to back, L = 1 → JALR: WRITEBACK with wb_sel = 10, pc_src = 10. STORE: mem_write high for exactly one cycle with pc_en. instret = 2 after 10 cycles.
- Opcode 1111111 → TRAP, illegal = 1 held for 20 cycles with no strobes. Opcode 1110011 → halted = 1. Pulsing rst_n low clears both flags and returns the FSM to FETCH.
- run = 0 after reset → FSM holds in FETCH for 10 cycles with instret = 0. Assert rst_n low during MEM_WAIT → strobes drop immediately and no reg_write follows.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer: state machine, strobes, selects, retire/halt/illegal status
// Outputs decode combinationally from the state register and the live opcode field.
module multicycle_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        take_branch,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        mem_addr_sel,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [31:0] instret,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXECUTE    = 4'd3,
    S_MEM        = 4'd4,
    S_MEM_WAIT   = 4'd5,
    S_WRITEBACK  = 4'd6,
    S_HALT       = 4'd7,
    S_TRAP       = 4'd8
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_instret;
  logic        r_halted;
  logic        r_illegal;
  logic        w_known;

  always_comb begin
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: w_known = 1'b1;
      default:                          w_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cnt     <= 2'd0;
      r_instret <= 32'd0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (pc_en) r_instret <= r_instret + 32'd1;
      case (r_state)
        S_FETCH: if (run) begin
          r_state <= S_FETCH_WAIT;
          r_cnt   <= LAT_M1;
        end
        S_FETCH_WAIT: begin
          if (r_cnt == 2'd0) r_state <= S_DECODE;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        S_DECODE: begin
          if (opcode == OP_SYSTEM) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_known) begin
            r_state <= S_EXECUTE;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (opcode == OP_BRANCH)                           r_state <= S_FETCH;
          else if (opcode == OP_LOAD || opcode == OP_STORE)  r_state <= S_MEM;
          else                                               r_state <= S_WRITEBACK;
        end
        S_MEM: begin
          if (opcode == OP_LOAD) begin
            r_state <= S_MEM_WAIT;
            r_cnt   <= LAT_M1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM_WAIT: begin
          if (r_cnt == 2'd0) r_state <= S_WRITEBACK;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        S_WRITEBACK: r_state <= S_FETCH;
        S_HALT:      r_state <= S_HALT;
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes exist only in the states that own them; every other state drives all zeros.
  always_comb begin
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_src       = 2'b00;
    mem_addr_sel = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    case (r_state)
      S_FETCH_WAIT: ir_en = (r_cnt == 2'd0);
      S_EXECUTE: begin
        alu_b_sel = !(opcode == OP_OP || opcode == OP_BRANCH);
        alu_a_sel = (opcode == OP_AUIPC);
        if (opcode == OP_BRANCH) begin
          pc_en  = 1'b1;
          pc_src = take_branch ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mem_addr_sel = 1'b1;
        if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          pc_en     = 1'b1;
        end
      end
      S_MEM_WAIT: mem_addr_sel = 1'b1;
      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        case (opcode)
          OP_LOAD:         wb_sel = 2'b01;
          OP_JAL, OP_JALR: wb_sel = 2'b10;
          OP_LUI:          wb_sel = 2'b11;
          default:         wb_sel = 2'b00;
        endcase
        if (opcode == OP_JAL)       pc_src = 2'b01;
        else if (opcode == OP_JALR) pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  assign instret = r_instret;
  assign halted  = r_halted;
  assign illegal = r_illegal;
  assign state_o = r_state;

endmodule
